// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared constants, helpers and state encoding for the frame
//                buffer read path (frame_reader and its pixel FIFO).
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    // Width of a coordinate counter that spans 0..n-1 (never zero bits wide)
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DATA_SIZE  = 8;
    localparam int ADDR_SIZE  = 14;
    localparam int IMG_W      = 128;
    localparam int IMG_H      = 128;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME_PIX  = IMG_W * IMG_H;
    localparam int COL_W      = coord_width(IMG_W);
    localparam int ROW_W      = coord_width(IMG_H);

    // Reader sequencing: IDLE waits for start, RUN issues addresses,
    // DRAIN waits for the tail of the frame to leave the stream.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_fifo
//  Description : Small synchronous FIFO holding pixel data plus coordinates.
//                Head entry is visible combinationally (first-word fall-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage array: data only, contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : frame_reader
//  Description : Sweeps the frame buffer RAM in raster order, absorbs its
//                one-cycle read latency and presents pixels on a valid/ready
//                stream with row/column, end-of-line and end-of-frame markers.
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_reader #(
    parameter int DATA_SIZE  = sobel_pkg::DATA_SIZE,
    parameter int ADDR_SIZE  = sobel_pkg::ADDR_SIZE,
    parameter int IMG_W      = sobel_pkg::IMG_W,
    parameter int IMG_H      = sobel_pkg::IMG_H,
    parameter int FIFO_DEPTH = sobel_pkg::FIFO_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    output logic                                          busy,
    output logic                                          done,
    output logic [ADDR_SIZE-1:0]                          ram_read_addr,
    input  logic [DATA_SIZE-1:0]                          ram_data_in,
    output logic [DATA_SIZE-1:0]                          px_data,
    output logic                                          px_valid,
    input  logic                                          px_ready,
    output logic [sobel_pkg::coord_width(IMG_W)-1:0]      px_col,
    output logic [sobel_pkg::coord_width(IMG_H)-1:0]      px_row,
    output logic                                          px_eol,
    output logic                                          px_last
);

    import sobel_pkg::*;

    localparam int COL_W     = coord_width(IMG_W);
    localparam int ROW_W     = coord_width(IMG_H);
    localparam int FRAME_PIX = IMG_W * IMG_H;
    localparam int ENTRY_W   = DATA_SIZE + ROW_W + COL_W;
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W      = CNT_W + 1;

    localparam logic [ADDR_SIZE:0] c_LAST_ADDR = (ADDR_SIZE + 1)'(FRAME_PIX - 1);
    localparam logic [COL_W-1:0]   c_LAST_COL  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]   c_LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [CR_W-1:0]    c_CREDITS   = CR_W'(FIFO_DEPTH);

    rd_state_t              r_state;
    rd_state_t              w_state_nxt;

    // r_next_addr is one bit wider so it can step past the last address
    logic [ADDR_SIZE:0]     r_next_addr;
    logic [ADDR_SIZE-1:0]   r_ram_read_addr;
    logic                   r_iss1;
    logic                   r_iss2;
    logic                   r_busy;
    logic                   r_done;
    logic [COL_W-1:0]       r_wr_col;
    logic [ROW_W-1:0]       r_wr_row;

    logic [CNT_W-1:0]       w_fifo_count;
    logic                   w_fifo_empty;
    logic [ENTRY_W-1:0]     w_head;
    logic [ENTRY_W-1:0]     w_push_entry;
    logic [CR_W-1:0]        w_credit_used;
    logic                   w_issue;
    logic                   w_start_acc;
    logic                   w_pop;
    logic                   w_final_hs;

    // Slots already claimed: buffered pixels plus reads still in the RAM pipe.
    // Built from registered state only, so px_ready never reaches the address.
    assign w_credit_used = CR_W'(w_fifo_count) + CR_W'(r_iss1) + CR_W'(r_iss2);

    assign w_push_entry  = {ram_data_in, r_wr_row, r_wr_col};
    assign px_valid      = !w_fifo_empty;
    assign {px_data, px_row, px_col} = w_fifo_empty ? '0 : w_head;
    assign px_eol        = px_valid && (px_col == c_LAST_COL);
    assign px_last       = px_eol && (px_row == c_LAST_ROW);
    assign w_pop         = px_valid && px_ready;
    assign w_final_hs    = w_pop && px_last;

    assign ram_read_addr = r_ram_read_addr;
    assign busy          = r_busy;
    assign done          = r_done;

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_iss2),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, start acceptance and address-issue decision
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is not taken
                if (start && !r_done) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_issue = (r_next_addr <= c_LAST_ADDR) && (w_credit_used < c_CREDITS);
                if (w_final_hs) begin
                    w_state_nxt = ST_IDLE;
                end else if ((w_issue && (r_next_addr == c_LAST_ADDR)) ||
                             (r_next_addr > c_LAST_ADDR)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_final_hs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // RAM address issue and read-latency tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_read_addr <= '0;
            r_next_addr     <= '0;
            r_iss1          <= 1'b0;
            r_iss2          <= 1'b0;
        end else begin
            r_iss2 <= r_iss1;
            if (w_start_acc) begin
                r_ram_read_addr <= '0;
                r_next_addr     <= (ADDR_SIZE + 1)'(1);
                r_iss1          <= 1'b1;
            end else if (w_issue) begin
                r_ram_read_addr <= r_next_addr[ADDR_SIZE-1:0];
                r_next_addr     <= r_next_addr + 1'b1;
                r_iss1          <= 1'b1;
            end else begin
                r_iss1          <= 1'b0;
            end
        end
    end

    // Coordinates of the next pixel entering the FIFO
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_col <= '0;
            r_wr_row <= '0;
        end else if (w_start_acc) begin
            r_wr_col <= '0;
            r_wr_row <= '0;
        end else if (r_iss2) begin
            if (r_wr_col == c_LAST_COL) begin
                r_wr_col <= '0;
                r_wr_row <= (r_wr_row == c_LAST_ROW) ? '0 : r_wr_row + 1'b1;
            end else begin
                r_wr_col <= r_wr_col + 1'b1;
            end
        end
    end

    // Frame status: busy spans start to final handshake, done is a 1-cycle pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                r_busy <= 1'b1;
            end
            if (w_final_hs) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_reader
//  Description : Self-checking bench for frame_reader: a 4x4 instance for the
//                directed stream scenarios and a 128x128 instance for a full
//                default-size frame. RAM models return pixel = address.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_reader;

    logic        clk = 1'b0;
    logic        rst;

    // 4x4 instance
    logic        s_start, s_busy, s_done, s_valid, s_ready, s_eol, s_last;
    logic [13:0] s_addr;
    logic [7:0]  s_ram_q, s_data;
    logic [1:0]  s_col, s_row;

    // 128x128 instance
    logic        l_start, l_busy, l_done, l_valid, l_ready, l_eol, l_last;
    logic [13:0] l_addr;
    logic [7:0]  l_ram_q, l_data;
    logic [6:0]  l_col, l_row;

    int checks = 0;
    int errors = 0;

    logic [31:0] sq_s[$];
    logic [31:0] sq_l[$];

    always #5 clk = ~clk;

    frame_reader #(.DATA_SIZE(8), .ADDR_SIZE(14), .IMG_W(4), .IMG_H(4), .FIFO_DEPTH(4)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
        .ram_read_addr(s_addr), .ram_data_in(s_ram_q),
        .px_data(s_data), .px_valid(s_valid), .px_ready(s_ready),
        .px_col(s_col), .px_row(s_row), .px_eol(s_eol), .px_last(s_last)
    );

    frame_reader dut_l (
        .clk(clk), .rst(rst), .start(l_start), .busy(l_busy), .done(l_done),
        .ram_read_addr(l_addr), .ram_data_in(l_ram_q),
        .px_data(l_data), .px_valid(l_valid), .px_ready(l_ready),
        .px_col(l_col), .px_row(l_row), .px_eol(l_eol), .px_last(l_last)
    );

    // Registered-address RAMs preloaded with pixel = address (low 8 bits)
    always @(posedge clk) begin
        s_ram_q <= s_addr[7:0];
        l_ram_q <= l_addr[7:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Expected stream word: {valid, 5'b0, last, eol, row, col, data}
    function automatic logic [31:0] exp_entry(input int idx, input int w, input int h);
        logic [31:0] e;
        int c;
        int r;
        c = idx % w;
        r = idx / w;
        e = '0;
        e[31]    = 1'b1;
        e[25]    = (idx == w * h - 1);
        e[24]    = (c == w - 1);
        e[23:16] = 8'(r);
        e[15:8]  = 8'(c);
        e[7:0]   = 8'(idx);
        return e;
    endfunction

    function automatic logic [31:0] small_obs();
        return {s_valid, 5'd0, s_last, s_eol, 6'd0, s_row, 6'd0, s_col, s_data};
    endfunction

    function automatic logic [31:0] large_obs();
        return {l_valid, 5'd0, l_last, l_eol, 1'b0, l_row, 1'b0, l_col, l_data};
    endfunction

    // Pulse start on the 4x4 instance and queue its whole frame
    task automatic start_small();
        for (int i = 0; i < 16; i++) sq_s.push_back(exp_entry(i, 4, 4));
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
    endtask

    // Consume one frame from the 4x4 instance; returns in the done cycle
    // (or right after handshake number stop_after when stop_after >= 0).
    task automatic run_small(input int pat, input int stop_after, output int first_valid,
                             output int busy_cycles, output int addr_at_19, output int max_cnt);
        int          k = 0;
        int          pix_n = 0;
        bit          last_hs = 1'b0;
        bit          prev_stall = 1'b0;
        bit          addr_bad = 1'b0;
        logic [31:0] prev_obs = '0;
        logic [31:0] obs;
        logic [31:0] exp_v;
        logic [13:0] prev_addr;
        first_valid = -1;
        busy_cycles = 0;
        addr_at_19  = -1;
        max_cnt     = 0;
        prev_addr   = s_addr;
        while (k < 400) begin
            if (last_hs) begin
                check("done_pulse", 32'(s_done), 32'd1);
                check("busy_clear", 32'(s_busy), 32'd0);
                check("addr_order", 32'(addr_bad), 32'd0);
                return;
            end
            check("done_early", 32'(s_done), 32'd0);
            case (pat)
                0:       s_ready = 1'b1;
                1:       s_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: s_ready = (k >= 20);
            endcase
            s_start = (k == 5);
            obs = small_obs();
            if (s_busy) busy_cycles++;
            if (s_valid && first_valid < 0) first_valid = k;
            if (k == 19) addr_at_19 = int'(s_addr);
            if (int'(dut_s.w_fifo_count) > max_cnt) max_cnt = int'(dut_s.w_fifo_count);
            if (s_addr < prev_addr) addr_bad = 1'b1;
            prev_addr = s_addr;
            if (prev_stall) check("hold_stable", obs, prev_obs);
            if (s_valid && s_ready) begin
                if (sq_s.size() == 0) begin
                    check("extra_pixel", 32'(sq_s.size()), 32'd1);
                end else begin
                    exp_v = sq_s.pop_front();
                    check("pixel", obs, exp_v);
                    last_hs = exp_v[25];
                end
                if (pix_n == stop_after) begin
                    @(posedge clk); #1;
                    s_start = 1'b0;
                    return;
                end
                pix_n++;
            end
            prev_stall = s_valid && !s_ready;
            prev_obs   = obs;
            @(posedge clk); #1;
            k++;
        end
        s_start = 1'b0;
        check("timeout_done", 32'(s_done), 32'd1);
    endtask

    initial begin
        int          fv, bc, a19, mc;
        int          n, lbc, lk;
        bit          fin;
        logic [31:0] obs;
        logic [31:0] exp_v;
        logic [15:0] last_rc;

        rst = 1'b1; s_start = 1'b0; s_ready = 1'b0; l_start = 1'b0; l_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_addr", 32'(s_addr), 32'd0);
        check("reset_stream", small_obs(), 32'd0);
        check("reset_status", 32'({s_busy, s_done}), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Full-rate frame: latency, sequence, markers, done, busy length
        start_small();
        run_small(0, -1, fv, bc, a19, mc);
        check("first_valid_latency", 32'(fv), 32'd2);
        check("busy_cycles_4x4", 32'(bc), 32'd18);
        check("fifo_bound_full_rate", 32'(mc <= 4), 32'd1);

        // Start in the done cycle is ignored; one cycle later it is accepted
        s_start = 1'b1;
        @(posedge clk); #1;
        check("start_in_done_ignored", 32'(s_busy), 32'd0);
        start_small();
        check("start_after_done_taken", 32'(s_busy), 32'd1);
        run_small(1, -1, fv, bc, a19, mc);
        check("fifo_bound_toggle", 32'(mc <= 4), 32'd1);
        check("queue_empty_toggle", 32'(sq_s.size()), 32'd0);

        // Long initial stall: reads stop at address 3, buffer holds 4
        repeat (2) @(posedge clk);
        #1;
        start_small();
        run_small(2, -1, fv, bc, a19, mc);
        check("stall_addr_hold", 32'(a19), 32'd3);
        check("stall_fifo_full", 32'(mc), 32'd4);

        // Asynchronous reset after pixel 5, then a clean restart
        repeat (2) @(posedge clk);
        #1;
        start_small();
        run_small(0, 5, fv, bc, a19, mc);
        #2 rst = 1'b1;
        #1;
        check("async_rst_addr", 32'(s_addr), 32'd0);
        check("async_rst_stream", small_obs(), 32'd0);
        check("async_rst_status", 32'({s_busy, s_done}), 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 32'({s_busy, s_done}), 32'd0);
        end
        sq_s.delete();
        start_small();
        run_small(0, -1, fv, bc, a19, mc);
        check("restart_latency", 32'(fv), 32'd2);

        // Default-size 128x128 frame at full rate
        for (int i = 0; i < 16384; i++) sq_l.push_back(exp_entry(i, 128, 128));
        l_ready = 1'b1;
        l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        n = 0; lbc = 0; lk = 0; fin = 1'b0; last_rc = '0;
        while (!fin && lk < 20000) begin
            if (l_busy) lbc++;
            if (l_done) begin
                fin = 1'b1;
            end else if (l_valid) begin
                obs = large_obs();
                if (sq_l.size() == 0) begin
                    check("large_extra_pixel", 32'(sq_l.size()), 32'd1);
                end else begin
                    exp_v = sq_l.pop_front();
                    check("large_pixel", obs, exp_v);
                end
                if (l_last) last_rc = {1'b0, l_row, 1'b0, l_col};
                n++;
            end
            @(posedge clk); #1;
            lk++;
        end
        check("large_done_seen", 32'(fin), 32'd1);
        check("large_pixel_count", 32'(n), 32'd16384);
        check("large_busy_cycles", 32'(lbc), 32'd16386);
        check("large_last_rowcol", 32'(last_rc), 32'h7f7f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Read-side client of the frame buffer block RAM (128x128, 8-bit pixels, 1-cycle registered-address read).
- On `start`, sweeps every address 0..IMG_W*IMG_H-1 in raster order and drives the RAM read address.
- Absorbs the RAM read latency and emits pixels on a valid/ready stream with row/column and end-of-line/end-of-frame markers.
- Feeds the Sobel window stage, or UART/VGA output for a processed frame.

Parameters:
- DATA_SIZE, 8, pixel width in bits.
- ADDR_SIZE, 14, RAM address width.
- IMG_W, 128, pixels per row.
- IMG_H, 128, rows per frame; IMG_W*IMG_H must be <= 2**ADDR_SIZE.
- FIFO_DEPTH, 4, output buffer entries; fixed at 4 for full throughput, not to be reduced.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sampled in IDLE only; begins one frame sweep.
- busy  out  1  high from the start accept until frame completion.
- done  out  1  single-cycle pulse when the last pixel is handshaken.
- ram_read_addr  out  ADDR_SIZE  to the RAM read address; registered.
- ram_data_in  in  DATA_SIZE  from the RAM data output; valid the cycle after the RAM samples the address.
- px_data  out  DATA_SIZE  stream pixel.
- px_valid  out  1  stream valid.
- px_ready  in  1  stream ready from the downstream stage.
- px_col  out  log2(IMG_W)  column of px_data.
- px_row  out  log2(IMG_H)  row of px_data.
- px_eol  out  1  high when px_col == IMG_W-1.
- px_last  out  1  high on pixel IMG_W*IMG_H-1.

Behaviour:
Reset (async, rst=1):
- State IDLE; ram_read_addr=0; issue pipeline flags iss1/iss2=0.
- FIFO emptied; px_valid=0, px_data=0, px_col=0, px_row=0, px_eol=0, px_last=0.
- busy=0, done=0.
- Reset mid-frame abandons the frame; no done pulse.

States: IDLE, RUN, DRAIN.
- IDLE, start=1 at edge N: go to RUN, busy=1, ram_read_addr<=0, iss1<=1.
- RUN issue rule: issue when next_addr <= IMG_W*IMG_H-1 and (fifo_count + iss1 + iss2) < 4, using registered values only.
  - No combinational path from px_ready to ram_read_addr.
  - Issue means ram_read_addr<=next_addr, next_addr+1, iss1<=1; otherwise iss1<=0 and ram_read_addr holds (a re-read is harmless).
- Pipeline: iss2<=iss1 each edge. At each edge where iss2=1, push ram_data_in into the FIFO.
- Latency: the first pixel push is at edge N+2, so px_valid first rises after edge N+2.
- Throughput: 1 pixel/clk sustained while px_ready=1. The credit rule guarantees the FIFO never overflows.
- RUN -> DRAIN once the last address is issued. DRAIN waits for the FIFO to empty and the final handshake.
- Final handshake: px_valid & px_ready with px_last=1 asserts done for one cycle (the cycle after that edge), busy<=0, state IDLE.
- A new start is accepted the cycle after done.
- start while busy is ignored.

Stream rules:
- Pop on px_valid & px_ready.
- px_data, px_col, px_row, px_eol and px_last are stable while px_valid=1 and px_ready=0.
- px_valid never drops without a handshake.
- px_valid = FIFO not empty.

Coordinates and markers:
- px_col/px_row track the FIFO head. They are held in the FIFO with the data, or derived from a pop counter.
- Wrap: col IMG_W-1 -> 0 with row+1.
- px_last coincides with row=IMG_H-1 and col=IMG_W-1.

Backpressure:
- px_ready low for any duration stalls issue after at most 2 extra reads in flight.
- No pixel is lost or duplicated.
- Address order stays strictly increasing.

Decomposition:
- Package sobel_pkg: DATA_SIZE, ADDR_SIZE, IMG_W, IMG_H, the derived FRAME_PIX=IMG_W*IMG_H and coordinate widths, and the state encoding.
- Sub-module pixel_fifo: a 4-entry synchronous FIFO.
  - Width DATA_SIZE + coordinate bits; push/pop/count/empty.
  - Same clk and async rst.
- Everything else lives in frame_reader.

Test Plan:
- IMG_W=4, IMG_H=4, RAM preloaded with pixel = address, px_ready=1: start pulse at cycle 0. Required:
  - px_valid first at cycle 2.
  - 16 consecutive pixels 0..15.
  - px_eol on 3, 7, 11, 15; px_last on 15 only.
  - done pulse the cycle after pixel 15.
- Same image, px_ready toggling 1,0,0,1 repeatedly: required exact sequence 0..15 with no gaps or repeats, data held stable during stalls, and FIFO count never > 4.
- px_ready=0 for 20 cycles after start: required at most 4 pixels buffered, and ram_read_addr stops advancing at 3. On release, the stream resumes with 0,1,2,...
- Reset mid-frame: rst asserted after pixel 5 is handshaken. Required:
  - All outputs 0 immediately (async).
  - No done pulse.
  - The next start restarts at pixel 0.
- Default 128x128, px_ready=1: required 16384 pixels, px_row/px_col = (127,127) on px_last, busy high for 16384+2 cycles.
- start asserted while busy and again in the cycle of done: required both ignored. A start in the cycle after done starts a second frame.
